mem_bus_bridge: RTL and testbench

- Sits directly downstream of the M-stage memory-access unit. Consumes its SRAM-like request (en, rlen, wen, addr, wdata) and returns read data to it.
- Converts the single-cycle SRAM-like request into a req/addr_ok/data_ok split-transaction bus request, toward the cache/AXI wrapper.
- Raises a pipeline stall while a transaction is outstanding.
- Holds the returned read data until the M stage advances.
- Performs fixed kseg0/kseg1 address translation and flags uncached accesses.

---
 rtl/mem_bus_pkg.sv | 35 +++
 rtl/addr_xlate.sv | 18 +
 rtl/mem_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_mem_bus_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the M-stage memory bus bridge and its helpers.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ADDR,
        ST_WAIT_DATA,
        ST_DONE
    } bridge_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] KSEG0_HI = 3'b100;
    localparam logic [2:0] KSEG1_HI = 3'b101;

    // Store size is implied by the strobe pattern; illegal patterns fall to byte.
    function automatic logic [1:0] wstrb_size(input logic [3:0] wstrb);
        case (wstrb)
            4'b1111:          return SIZE_W;
            4'b0011, 4'b1100: return SIZE_H;
            default:          return SIZE_B;
        endcase
    endfunction

    function automatic logic wstrb_legal(input logic [3:0] wstrb);
        case (wstrb)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/addr_xlate.sv
// Fixed kseg0/kseg1 virtual-to-physical mapping; shared by fetch and data paths.
module addr_xlate
    import mem_bus_pkg::*;
#(
    parameter bit KSEG_XLATE = 1'b1
) (
    input  logic [31:0] vaddr_i,
    output logic [31:0] paddr_o,
    output logic        uncached_o
);

    logic in_kseg01;

    assign in_kseg01  = (vaddr_i[31:29] == KSEG0_HI) || (vaddr_i[31:29] == KSEG1_HI);
    assign uncached_o = (vaddr_i[31:29] == KSEG1_HI);
    assign paddr_o    = (KSEG_XLATE && in_kseg01) ? {3'b000, vaddr_i[28:0]} : vaddr_i;

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns the M-stage SRAM-like access into a req/addr_ok/data_ok bus transaction,
// stalling the pipe until it completes and holding read data until M advances.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter bit KSEG_XLATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [1:0]  data_sram_rlen,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        m_advance,
    input  logic        flush,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_uncached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    bridge_state_t state_q, state_d;
    logic          drop_q, drop_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          wr_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          unc_q;

    logic [31:0]   paddr;
    logic          unc;
    logic          wr_in;
    logic [1:0]    size_in;
    logic          issue;

    addr_xlate #(.KSEG_XLATE(KSEG_XLATE)) u_xlate (
        .vaddr_i    (data_sram_addr),
        .paddr_o    (paddr),
        .uncached_o (unc)
    );

    assign wr_in   = |data_sram_wen;
    assign size_in = wr_in ? wstrb_size(data_sram_wen) : data_sram_rlen;
    // Gated by rst so every output is quiet while reset is held, even with en high.
    assign issue   = ~rst & (state_q == ST_IDLE) & data_sram_en & ~flush;

    assign data_sram_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            if (issue) begin
                wr_q    <= wr_in;
                size_q  <= size_in;
                addr_q  <= paddr;
                wdata_q <= data_sram_wdata;
                wstrb_q <= data_sram_wen;
                unc_q   <= unc;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        rdata_d      = rdata_q;
        mem_stall    = 1'b0;
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = SIZE_B;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_wstrb    = '0;
        bus_uncached = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    mem_stall    = 1'b1;
                    bus_req      = 1'b1;
                    bus_wr       = wr_in;
                    bus_size     = size_in;
                    bus_addr     = paddr;
                    bus_wdata    = data_sram_wdata;
                    bus_wstrb    = data_sram_wen;
                    bus_uncached = unc;
                    state_d      = bus_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                // A posted request cannot be withdrawn; a flush only marks it for discard.
                mem_stall    = 1'b1;
                bus_req      = 1'b1;
                bus_wr       = wr_q;
                bus_size     = size_q;
                bus_addr     = addr_q;
                bus_wdata    = wdata_q;
                bus_wstrb    = wstrb_q;
                bus_uncached = unc_q;
                if (flush)       drop_d  = 1'b1;
                if (bus_addr_ok) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                mem_stall = 1'b1;
                if (bus_data_ok) begin
                    if (drop_q || flush) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        if (!wr_q) rdata_d = bus_rdata;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (m_advance || flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    a_wstrb_legal: assert property (@(posedge clk) disable iff (rst)
        (issue && wr_in) |-> wstrb_legal(data_sram_wen));

    a_data_ok_expected: assert property (@(posedge clk) disable iff (rst)
        bus_data_ok |-> (state_q == ST_WAIT_DATA));

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge against a transaction-level reference model.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [1:0]  data_sram_rlen;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        m_advance;
    logic        flush;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_uncached;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    mem_bus_bridge #(.KSEG_XLATE(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_rlen  (data_sram_rlen),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .m_advance       (m_advance),
        .flush           (flush),
        .mem_stall       (mem_stall),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_uncached    (bus_uncached),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // kseg0 starts at 0x8000_0000 and kseg1 at 0xA000_0000, each 512 MB, both mapped to 0.
    function automatic logic [31:0] ref_paddr(input logic [31:0] va);
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        return va;
    endfunction

    function automatic logic ref_uncached(input logic [31:0] va);
        return (va >= 32'hA000_0000 && va < 32'hC000_0000);
    endfunction

    // Bytes written: 4 -> word, 2 -> half, 1 -> byte.
    function automatic logic [1:0] ref_size(input logic [3:0] wen, input logic [1:0] rlen);
        int n;
        n = $countones(wen);
        if (n == 0) return rlen;
        if (n == 4) return 2'd2;
        return 2'(n - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"},   bus_req,   0);
        check_eq({tag, "_stall"}, mem_stall, 0);
        check_eq({tag, "_addr"},  bus_addr,  0);
        check_eq({tag, "_wstrb"}, bus_wstrb, 0);
        check_eq({tag, "_rdata"}, data_sram_rdata, exp_rdata);
    endtask

    // One full access: a = extra WAIT_ADDR cycles, d = extra WAIT_DATA cycles, hold = DONE cycles before advance.
    task automatic run_txn(input logic [3:0] wen, input logic [1:0] rlen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int a, input int d, input int hold);
        logic [31:0] pa;
        logic        unc;
        logic [1:0]  sz;
        int          stalls;
        pa     = ref_paddr(addr);
        unc    = ref_uncached(addr);
        sz     = ref_size(wen, rlen);
        stalls = 0;
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_rlen  = rlen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        m_advance       = 1'b0;
        flush           = 1'b0;
        for (int c = 0; c <= a; c++) begin
            bus_addr_ok = (c == a);
            bus_data_ok = 1'b0;
            bus_rdata   = $urandom;
            if (c > 0) begin
                data_sram_addr  = $urandom;
                data_sram_wdata = $urandom;
            end
            @(negedge clk);
            check_eq("req",       bus_req,      1);
            check_eq("req_wr",    bus_wr,       (wen != 0));
            check_eq("req_size",  bus_size,     sz);
            check_eq("req_addr",  bus_addr,     pa);
            check_eq("req_wdata", bus_wdata,    wdata);
            check_eq("req_wstrb", bus_wstrb,    wen);
            check_eq("req_unc",   bus_uncached, unc);
            check_eq("req_rdata", data_sram_rdata, exp_rdata);
            stalls += int'(mem_stall);
            step();
        end
        for (int i = 0; i <= d; i++) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = (i == d);
            bus_rdata   = (i == d) ? rd : $urandom;
            @(negedge clk);
            check_eq("data_req",   bus_req,   0);
            check_eq("data_stall", mem_stall, 1);
            stalls += int'(mem_stall);
            step();
        end
        if (wen == 4'b0000) exp_rdata = rd;
        bus_data_ok = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            m_advance = (h == hold);
            bus_rdata = $urandom;
            @(negedge clk);
            check_eq("done_req",   bus_req,   0);
            check_eq("done_stall", mem_stall, 0);
            check_eq("done_rdata", data_sram_rdata, exp_rdata);
            step();
        end
        check_eq("stall_cycles", stalls, 2 + a + d);
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        m_advance     = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        step();
    endtask

    // Load that gets flushed (in WAIT_ADDR when a>0, else in WAIT_DATA) and is drained.
    task automatic flush_txn(input logic [31:0] addr, input int a, input int d);
        logic [31:0] pa;
        pa = ref_paddr(addr);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_rlen = 2'd2;
        data_sram_addr = addr;
        m_advance      = 1'b0;
        flush          = 1'b0;
        for (int c = 0; c <= a; c++) begin
            bus_addr_ok = (c == a);
            bus_data_ok = 1'b0;
            flush       = (c == 1);
            if (c > 1) data_sram_addr = $urandom;
            @(negedge clk);
            check_eq("fl_req",   bus_req,   1);
            check_eq("fl_addr",  bus_addr,  pa);
            check_eq("fl_stall", mem_stall, 1);
            step();
        end
        flush = (a == 0);
        for (int i = 0; i <= d; i++) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = (i == d);
            bus_rdata   = $urandom;
            if (i > 0) begin
                flush          = 1'b0;
                data_sram_addr = $urandom;
            end
            @(negedge clk);
            check_eq("drain_req",   bus_req,   0);
            check_eq("drain_stall", mem_stall, 1);
            step();
        end
        flush       = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [2:0]  hi;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       hi = 3'b000;
            1:       hi = 3'b100;
            2:       hi = 3'b101;
            default: hi = r[31:29];
        endcase
        return {hi, r[28:0]};
    endfunction

    function automatic logic [3:0] rand_wen();
        case ($urandom_range(0, 6))
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b0011;
            5: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    initial begin
        rst             = 1'b1;
        data_sram_en    = 1'b1;
        data_sram_rlen  = 2'd2;
        data_sram_wen   = 4'b1111;
        data_sram_addr  = 32'h8000_0000;
        data_sram_wdata = 32'h1234_5678;
        m_advance       = 1'b0;
        flush           = 1'b0;
        bus_addr_ok     = 1'b0;
        bus_data_ok     = 1'b0;
        bus_rdata       = '0;
        exp_rdata       = '0;

        @(negedge clk);
        check_quiet("rst");
        step();
        rst           = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;

        run_txn(4'b0000, 2'd2, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
        run_txn(4'b1000, 2'd0, 32'hBFAF_F003, 32'hAB00_0000, 32'h0BAD_F00D, 3, 0, 1);
        run_txn(4'b1100, 2'd0, 32'h8000_2002, 32'hCAFE_0000, 32'h1111_1111, 0, 1, 0);
        run_txn(4'b1111, 2'd0, 32'h0040_0000, 32'h0102_0304, 32'h2222_2222, 1, 0, 0);
        run_txn(4'b0000, 2'd1, 32'hA000_0042, 32'h0,         32'h0000_BEEF, 0, 2, 0);
        run_txn(4'b0000, 2'd2, 32'h8000_0100, 32'h0,         32'h5A5A_A5A5, 0, 0, 4);

        flush_txn(32'h8000_0200, 0, 2);
        run_txn(4'b0000, 2'd2, 32'h8000_0300, 32'h0, 32'h3333_4444, 0, 0, 0);
        flush_txn(32'hA000_0400, 2, 1);
        run_txn(4'b0000, 2'd0, 32'h8000_0500, 32'h0, 32'h0000_0077, 1, 1, 0);
        flush_txn(32'h8000_0600, 0, 0);
        run_txn(4'b0000, 2'd2, 32'h8000_0700, 32'h0, 32'h7777_8888, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0)
                flush_txn(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
            if (kind == 1)
                run_txn(rand_wen(), 2'd0, rand_addr(), $urandom, $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                run_txn(4'b0000, 2'($urandom_range(0, 2)), rand_addr(), $urandom, $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset asserted mid WAIT_DATA, then a stray data_ok while still in reset.
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_rlen = 2'd2;
        data_sram_addr = 32'h8000_0800;
        bus_addr_ok    = 1'b1;
        bus_data_ok    = 1'b0;
        @(negedge clk);
        check_eq("rs_req", bus_req, 1);
        step();
        bus_addr_ok = 1'b0;
        @(negedge clk);
        check_eq("rs_wait_stall", mem_stall, 1);
        #2 rst = 1'b1;
        #1;
        exp_rdata = '0;
        check_quiet("rs_async");
        check_eq("rs_wr",   bus_wr,       0);
        check_eq("rs_unc",  bus_uncached, 0);
        check_eq("rs_size", bus_size,     0);
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hFFFF_0000;
        @(negedge clk);
        check_quiet("rs_stray");
        step();
        bus_data_ok  = 1'b0;
        rst          = 1'b0;
        data_sram_en = 1'b0;
        @(negedge clk);
        check_quiet("rs_idle");
        step();
        run_txn(4'b0000, 2'd2, 32'h8000_0900, 32'h0, 32'h9999_0001, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
